gshare_predictor: RTL

Branch direction predictor built from a table of 2-bit saturating counters, indexed by the branch PC XORed with a global history register (GHR). It sits in the fetch stage. A lookup returns a registered taken/not-taken prediction one cycle later. Resolved branches from execute come back on the update port and train both the counter table and the GHR.

---
 rtl/bp_pkg.sv | 26 ++
 rtl/bp_ghr.sv | 26 ++
 rtl/gshare_predictor.sv | 75 +++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encoding and
// the saturating counter next-state function.
package bp_pkg;

   localparam int CNT_W = 2;

   localparam logic [CNT_W-1:0] SNT = 2'b00;
   localparam logic [CNT_W-1:0] WNT = 2'b01;
   localparam logic [CNT_W-1:0] WT  = 2'b10;
   localparam logic [CNT_W-1:0] ST  = 2'b11;

   localparam logic [CNT_W-1:0] CNT_RESET = WNT;

   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                 input logic taken);
      logic [CNT_W-1:0] nxt;
      nxt = cnt;
      if (taken) begin
         if (cnt != ST) nxt = cnt + 1'b1;
      end else begin
         if (cnt != SNT) nxt = cnt - 1'b1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bp_ghr.sv
// Global history shift register; the newest outcome enters at bit 0.
module bp_ghr #(
   parameter int HIST_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              shift_en,
   input  logic              shift_in,
   output logic [HIST_W-1:0] ghr
);

   generate
      if (HIST_W > 1) begin : g_multi
         always_ff @(posedge clk or posedge reset) begin
            if (reset)         ghr <= '0;
            else if (shift_en) ghr <= {ghr[HIST_W-2:0], shift_in};
         end
      end else begin : g_single
         always_ff @(posedge clk or posedge reset) begin
            if (reset)         ghr <= '0;
            else if (shift_en) ghr <= shift_in;
         end
      end
   endgenerate

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC xor global history indexes a table of
// 2-bit saturating counters. Registered prediction, trained on resolve.
module gshare_predictor
   import bp_pkg::*;
#(
   parameter int IDX_W      = 4,
   parameter int HIST_W     = 4,
   parameter int PC_W       = 32,
   parameter int CNT_STAT_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  lookup_valid,
   input  logic [PC_W-1:0]       lookup_pc,
   output logic                  prediction,
   output logic                  prediction_valid,
   output logic [IDX_W-1:0]      pred_index,
   input  logic                  update_valid,
   input  logic [IDX_W-1:0]      update_index,
   input  logic                  update_taken,
   input  logic                  update_mispredict,
   output logic [HIST_W-1:0]     ghr,
   output logic [CNT_STAT_W-1:0] mispredict_count
);

   localparam int DEPTH = 2 ** IDX_W;

   logic [CNT_W-1:0] cnt_tbl [DEPTH];
   logic [IDX_W-1:0] idx;
   logic             pc_unused;

   // PC bits outside the index window never affect the prediction.
   assign pc_unused = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};
   assign idx       = lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr);

   bp_ghr #(.HIST_W(HIST_W)) u_ghr (
      .clk      (clk),
      .reset    (reset),
      .shift_en (update_valid),
      .shift_in (update_taken),
      .ghr      (ghr)
   );

   // Read-before-write: a same-cycle lookup sees the pre-update counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prediction       <= 1'b0;
         prediction_valid <= 1'b0;
         pred_index       <= '0;
      end else begin
         prediction_valid <= lookup_valid;
         if (lookup_valid) begin
            prediction <= cnt_tbl[idx][CNT_W-1];
            pred_index <= idx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) cnt_tbl[i] <= CNT_RESET;
      end else if (update_valid) begin
         cnt_tbl[update_index] <= cnt_next(cnt_tbl[update_index], update_taken);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mispredict_count <= '0;
      end else if (update_valid && update_mispredict && (mispredict_count != '1)) begin
         mispredict_count <= mispredict_count + 1'b1;
      end
   end

endmodule
